// File: rtl/onehot_decoder_pkg.sv
// Shared constants, buffer state type and the binary-to-one-hot decode function
// for onehot_decoder and its models.
package onehot_decoder_pkg;

    localparam int unsigned IN_W_DEF  = 3;
    localparam int unsigned OUT_W_DEF = 1 << IN_W_DEF;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } buf_state_e;

    // en=0 yields an all-zero word rather than a one-hot one.
    function automatic logic [OUT_W_DEF-1:0] decode(input logic [IN_W_DEF-1:0] code,
                                                    input logic                 en);
        logic [OUT_W_DEF-1:0] word;
        word = '0;
        if (en) begin
            word[code] = 1'b1;
        end
        return word;
    endfunction

endpackage

// File: rtl/onehot_skid_buf.sv
// Two-entry skid FIFO (EMPTY/ONE/FULL) presenting the head entry on out_data.
module onehot_skid_buf
    import onehot_decoder_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    buf_state_e        r_state, w_state_next;
    logic [DATA_W-1:0] r_head, w_head_next;
    logic [DATA_W-1:0] r_tail, w_tail_next;
    logic              w_push, w_pop;

    assign in_ready  = !rst && (r_state != StFull);
    assign out_valid = (r_state != StEmpty);
    assign out_data  = r_head;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_state_next = r_state;
        w_head_next  = r_head;
        w_tail_next  = r_tail;
        unique case (r_state)
            StEmpty: begin
                if (w_push) begin
                    w_head_next  = in_data;
                    w_state_next = StOne;
                end
            end
            StOne: begin
                // Push and pop together: the new word replaces the departing head.
                if (w_push && w_pop) begin
                    w_head_next = in_data;
                end else if (w_push) begin
                    w_tail_next  = in_data;
                    w_state_next = StFull;
                end else if (w_pop) begin
                    w_state_next = StEmpty;
                end
            end
            StFull: begin
                if (w_pop) begin
                    w_head_next  = r_tail;
                    w_state_next = StOne;
                end
            end
            default: w_state_next = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StEmpty;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_state_next;
            r_head  <= w_head_next;
            r_tail  <= w_tail_next;
        end
    end

endmodule

// File: rtl/onehot_decoder.sv
// Pipelined binary-to-one-hot decoder behind a 2-entry skid buffer.
// Optional per-line hit counters are built when ONEHOT_DECODER_HIT_COUNT_EN is defined.
module onehot_decoder
    import onehot_decoder_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   en,
    input  logic [IN_W-1:0]        code,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [(1 << IN_W)-1:0] q,
    input  logic [IN_W-1:0]        cnt_sel,
    output logic [CNT_W-1:0]       cnt_val
);

    localparam int unsigned OUT_W = 1 << IN_W;

    logic [OUT_W-1:0] w_word;

    if (IN_W == IN_W_DEF) begin : g_dec_pkg
        assign w_word = decode(code, en);
    end else begin : g_dec_gen
        assign w_word = en ? (OUT_W'(1) << code) : '0;
    end

    onehot_skid_buf #(
        .DATA_W (OUT_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (q)
    );

`ifdef ONEHOT_DECODER_HIT_COUNT_EN
    logic             w_pop;
    logic [CNT_W-1:0] w_cnt [OUT_W];
    logic [CNT_W-1:0] r_cnt_val;

    assign w_pop = out_valid && out_ready;

    for (genvar g = 0; g < OUT_W; g++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;

        // Saturating: a line that hits all-ones stays there until reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_pop && q[g] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end

        assign w_cnt[g] = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_val <= '0;
        end else begin
            r_cnt_val <= w_cnt[cnt_sel];
        end
    end

    assign cnt_val = r_cnt_val;
`else
    logic w_unused_cnt_sel;

    assign w_unused_cnt_sel = ^cnt_sel;
    assign cnt_val          = '0;
`endif

endmodule

// File: tb/tb_onehot_decoder.sv
// Directed, table-driven bench for onehot_decoder (both counter build options).
module tb_onehot_decoder;

    localparam int unsigned IN_W  = 3;
    localparam int unsigned OUT_W = 8;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             en;
    logic [IN_W-1:0]  code;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] q;
    logic [IN_W-1:0]  cnt_sel;
    logic [CNT_W-1:0] cnt_val;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    onehot_decoder #(
        .IN_W  (IN_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .en        (en),
        .code      (code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .cnt_sel   (cnt_sel),
        .cnt_val   (cnt_val)
    );

    typedef struct {
        logic             en;
        logic [IN_W-1:0]  code;
        logic [OUT_W-1:0] exp_q;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic e, input logic [IN_W-1:0] c);
        in_valid = 1'b1;
        en       = e;
        code     = c;
    endtask

    initial begin
        vecs[0] = '{1'b1, 3'd0, 8'h01};
        vecs[1] = '{1'b1, 3'd1, 8'h02};
        vecs[2] = '{1'b1, 3'd2, 8'h04};
        vecs[3] = '{1'b1, 3'd3, 8'h08};
        vecs[4] = '{1'b1, 3'd4, 8'h10};
        vecs[5] = '{1'b1, 3'd5, 8'h20};
        vecs[6] = '{1'b1, 3'd6, 8'h40};
        vecs[7] = '{1'b1, 3'd7, 8'h80};
        vecs[8] = '{1'b0, 3'd5, 8'h00};
        vecs[9] = '{1'b0, 3'd7, 8'h00};

        // Reset held 3 cycles with a code offered
        rst       = 1'b1;
        out_ready = 1'b0;
        cnt_sel   = 3'd0;
        push(1'b1, 3'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_in_ready", 32'(in_ready), 32'h0);
            check("rst_out_valid", 32'(out_valid), 32'h0);
            check("rst_q", 32'(q), 32'h0);
            check("rst_cnt_val", 32'(cnt_val), 32'h0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'h1);
        step();
        check("post_rst_no_word", 32'(out_valid), 32'h0);

        // Streaming decode, one word per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(vecs[i].en, vecs[i].code);
            step();
            check($sformatf("stream_valid[%0d]", i), 32'(out_valid), 32'h1);
            check($sformatf("stream_q[%0d]", i), 32'(q), 32'(vecs[i].exp_q));
            check($sformatf("stream_in_ready[%0d]", i), 32'(in_ready), 32'h1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain", 32'(out_valid), 32'h0);

        // Backpressure: codes 3, 6 fill the buffer, code 1 held off
        out_ready = 1'b0;
        push(1'b1, 3'd3);
        step();
        check("bp_first_q", 32'(q), 32'h08);
        check("bp_first_ready", 32'(in_ready), 32'h1);
        push(1'b1, 3'd6);
        step();
        check("bp_full_ready", 32'(in_ready), 32'h0);
        check("bp_full_q", 32'(q), 32'h08);
        push(1'b1, 3'd1);
        step();
        check("bp_held_ready", 32'(in_ready), 32'h0);
        check("bp_held_q", 32'(q), 32'h08);
        check("bp_held_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        step();
        check("bp_pop1_q", 32'(q), 32'h40);
        check("bp_recover_ready", 32'(in_ready), 32'h1);
        step();
        check("bp_pop2_q", 32'(q), 32'h02);
        check("bp_pop2_valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        step();
        check("bp_empty", 32'(out_valid), 32'h0);

        // Simultaneous push/pop in ONE
        out_ready = 1'b0;
        push(1'b1, 3'd2);
        step();
        check("pp_one_q", 32'(q), 32'h04);
        out_ready = 1'b1;
        push(1'b1, 3'd7);
        step();
        check("pp_new_head", 32'(q), 32'h80);
        check("pp_still_ready", 32'(in_ready), 32'h1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        push(1'b1, 3'd0);
        in_valid  = 1'b0;
        step();
        check("pp_stall_q", 32'(q), 32'h80);
        check("pp_stall_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        step();
        check("pp_single_pop_empties", 32'(out_valid), 32'h0);

        // Mid-stream reset while FULL
        out_ready = 1'b0;
        push(1'b1, 3'd1);
        step();
        push(1'b1, 3'd4);
        step();
        check("mr_full", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        check("mr_valid_cleared", 32'(out_valid), 32'h0);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("mr_no_stale[%0d]", i), 32'(out_valid), 32'h0);
        end

        // Hit counters: code 4 three times plus one zero word
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 3'd4);
            step();
        end
        push(1'b0, 3'd5);
        step();
        in_valid = 1'b0;
        step();
        cnt_sel = 3'd4;
        step();
`ifdef ONEHOT_DECODER_HIT_COUNT_EN
        check("cnt_line4", 32'(cnt_val), 32'd3);
        cnt_sel = 3'd0;
        step();
        check("cnt_line0", 32'(cnt_val), 32'd0);
        cnt_sel = 3'd5;
        step();
        check("cnt_zero_word_ignored", 32'(cnt_val), 32'd0);
        force dut.g_cnt[4].r_cnt = 16'hFFFF;
        step();
        release dut.g_cnt[4].r_cnt;
        push(1'b1, 3'd4);
        step();
        in_valid = 1'b0;
        step();
        cnt_sel = 3'd4;
        step();
        check("cnt_saturate", 32'(cnt_val), 32'hFFFF);
`else
        check("cnt_tied_line4", 32'(cnt_val), 32'd0);
        cnt_sel = 3'd0;
        step();
        check("cnt_tied_line0", 32'(cnt_val), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
